// File: rtl/guess_checker_pkg.sv
// -----------------------------------------------------------------------------
// guess_checker_pkg
// Shared definitions for the guessing game. The random number generator and
// the guess checker both import this package, so they agree on the number
// width and the game-state encoding.
// -----------------------------------------------------------------------------
package guess_checker_pkg;

    // Default width of the random number and of a player guess.
    localparam int unsigned GAME_WIDTH = 4;

    // Game-state encoding.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WON  = 2'b10;
    localparam logic [1:0] ST_LOST = 2'b11;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        PLAY = ST_PLAY,
        WON  = ST_WON,
        LOST = ST_LOST
    } game_state_e;

endpackage : guess_checker_pkg

// File: rtl/guess_checker.sv
// -----------------------------------------------------------------------------
// guess_checker
// A pulse on NewGame latches the current random number as the secret target.
// Each later GuessStrobe compares GuessInp against that target and reports
// high, low or match. The block counts attempts up to MAX_ATTEMPTS and flags
// a win or a loss. Every output comes from a register.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   NewGame     in   single-cycle pulse that starts (or restarts) a game
//   RandNum     in   free-running random number, sampled on NewGame
//   GuessStrobe in   single-cycle pulse, GuessInp valid
//   GuessInp    in   player guess
//   GuessHigh   out  last guess > target
//   GuessLow    out  last guess < target
//   GuessMatch  out  last guess == target
//   Attempts    out  guesses consumed this game
//   GameWon     out  game ended on a match (level)
//   GameLost    out  attempts exhausted without a match (level)
//   Target      out  latched target, debug display only
// -----------------------------------------------------------------------------
module guess_checker
    import guess_checker_pkg::*;
#(
    parameter int unsigned WIDTH        = GAME_WIDTH,
    parameter int unsigned MAX_ATTEMPTS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             NewGame,
    input  logic [WIDTH-1:0] RandNum,
    input  logic             GuessStrobe,
    input  logic [WIDTH-1:0] GuessInp,
    output logic             GuessHigh,
    output logic             GuessLow,
    output logic             GuessMatch,
    output logic [3:0]       Attempts,
    output logic             GameWon,
    output logic             GameLost,
    output logic [WIDTH-1:0] Target
);

    localparam logic [3:0] MAX_ATT = 4'(MAX_ATTEMPTS);

    game_state_e      state_q,    state_d;
    logic [WIDTH-1:0] target_q,   target_d;
    logic [3:0]       attempts_q, attempts_d;
    logic             high_q,     high_d;
    logic             low_q,      low_d;
    logic             match_q,    match_d;
    logic             won_q,      won_d;
    logic             lost_q,     lost_d;

    // Attempt count after the current guess; saturates at the limit.
    logic [3:0]       attempts_inc_s;

    // Next-state and next-output logic for the game FSM.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        attempts_d     = attempts_q;
        high_d         = high_q;
        low_d          = low_q;
        match_d        = match_q;
        won_d          = won_q;
        lost_d         = lost_q;
        attempts_inc_s = attempts_q;

        if (attempts_q < MAX_ATT) begin
            attempts_inc_s = attempts_q + 4'd1;
        end else begin
            attempts_inc_s = attempts_q;
        end

        // NewGame restarts from any state and takes priority over a guess
        // that arrives in the same cycle.
        if (NewGame) begin
            state_d    = PLAY;
            target_d   = RandNum;
            attempts_d = 4'd0;
            high_d     = 1'b0;
            low_d      = 1'b0;
            match_d    = 1'b0;
            won_d      = 1'b0;
            lost_d     = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (GuessStrobe) begin
                        high_d     = (GuessInp >  target_q);
                        low_d      = (GuessInp <  target_q);
                        match_d    = (GuessInp == target_q);
                        attempts_d = attempts_inc_s;
                        // A match on the last allowed attempt is a win.
                        if (GuessInp == target_q) begin
                            state_d = WON;
                            won_d   = 1'b1;
                        end else if (attempts_inc_s == MAX_ATT) begin
                            state_d = LOST;
                            lost_d  = 1'b1;
                        end else begin
                            state_d = PLAY;
                        end
                    end else begin
                        state_d = PLAY;
                    end
                end
                // IDLE, WON and LOST ignore guesses and hold their outputs.
                IDLE:    state_d = IDLE;
                WON:     state_d = WON;
                LOST:    state_d = LOST;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            target_q   <= '0;
            attempts_q <= 4'd0;
            high_q     <= 1'b0;
            low_q      <= 1'b0;
            match_q    <= 1'b0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            attempts_q <= attempts_d;
            high_q     <= high_d;
            low_q      <= low_d;
            match_q    <= match_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
        end
    end

    assign GuessHigh  = high_q;
    assign GuessLow   = low_q;
    assign GuessMatch = match_q;
    assign Attempts   = attempts_q;
    assign GameWon    = won_q;
    assign GameLost   = lost_q;
    assign Target     = target_q;

endmodule : guess_checker

// File: tb/tb_guess_checker.sv
module tb_guess_checker;

    localparam int W   = 4;
    localparam int MAX = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         NewGame = 1'b0;
    logic [W-1:0] RandNum = '0;
    logic         GuessStrobe = 1'b0;
    logic [W-1:0] GuessInp = '0;
    logic         GuessHigh, GuessLow, GuessMatch, GameWon, GameLost;
    logic [3:0]   Attempts;
    logic [W-1:0] Target;

    int total = 0;
    int bad   = 0;

    // Reference model: a game is either running or not; results are plain values.
    bit m_running = 1'b0;
    int m_target = 0, m_att = 0;
    bit m_high = 1'b0, m_low = 1'b0, m_match = 1'b0, m_won = 1'b0, m_lost = 1'b0;

    guess_checker #(.WIDTH(W), .MAX_ATTEMPTS(MAX)) dut (
        .clk(clk), .rst(rst), .NewGame(NewGame), .RandNum(RandNum),
        .GuessStrobe(GuessStrobe), .GuessInp(GuessInp),
        .GuessHigh(GuessHigh), .GuessLow(GuessLow), .GuessMatch(GuessMatch),
        .Attempts(Attempts), .GameWon(GameWon), .GameLost(GameLost),
        .Target(Target)
    );

    always #5 clk = ~clk;

    // Apply the game rules to the inputs seen at one clock edge.
    task automatic model_edge();
        int g;
        if (rst) begin
            m_running = 1'b0; m_target = 0; m_att = 0;
            m_high = 1'b0; m_low = 1'b0; m_match = 1'b0; m_won = 1'b0; m_lost = 1'b0;
        end else if (NewGame) begin
            m_running = 1'b1; m_target = int'(RandNum); m_att = 0;
            m_high = 1'b0; m_low = 1'b0; m_match = 1'b0; m_won = 1'b0; m_lost = 1'b0;
        end else if (m_running && GuessStrobe) begin
            g = int'(GuessInp);
            m_att   = m_att + 1;
            m_high  = (g > m_target);
            m_low   = (g < m_target);
            m_match = (g == m_target);
            if (m_match) begin
                m_won = 1'b1; m_running = 1'b0;
            end else if (m_att == MAX) begin
                m_lost = 1'b1; m_running = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        total++;
        assert (GuessHigh === m_high) else begin
            bad++; $error("FAIL %s GuessHigh observed=%0b expected=%0b", tag, GuessHigh, m_high);
        end
        total++;
        assert (GuessLow === m_low) else begin
            bad++; $error("FAIL %s GuessLow observed=%0b expected=%0b", tag, GuessLow, m_low);
        end
        total++;
        assert (GuessMatch === m_match) else begin
            bad++; $error("FAIL %s GuessMatch observed=%0b expected=%0b", tag, GuessMatch, m_match);
        end
        total++;
        assert (Attempts === 4'(m_att)) else begin
            bad++; $error("FAIL %s Attempts observed=%0d expected=%0d", tag, Attempts, m_att);
        end
        total++;
        assert (GameWon === m_won) else begin
            bad++; $error("FAIL %s GameWon observed=%0b expected=%0b", tag, GameWon, m_won);
        end
        total++;
        assert (GameLost === m_lost) else begin
            bad++; $error("FAIL %s GameLost observed=%0b expected=%0b", tag, GameLost, m_lost);
        end
        total++;
        assert (Target === 4'(m_target)) else begin
            bad++; $error("FAIL %s Target observed=%0d expected=%0d", tag, Target, m_target);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic cyc(input string tag, input logic r, input logic ng, input int rn,
                       input logic gs, input int gi);
        rst = r; NewGame = ng; RandNum = 4'(rn); GuessStrobe = gs; GuessInp = 4'(gi);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset, then a guess in IDLE must be ignored.
        cyc("reset1", 1'b1, 1'b0, 0, 1'b0, 0);
        cyc("reset2", 1'b1, 1'b0, 0, 1'b0, 0);
        cyc("idle_guess", 1'b0, 1'b0, 0, 1'b1, 5);
        cyc("idle_hold", 1'b0, 1'b0, 0, 1'b0, 0);

        // Win path: target 9, guesses 3, 12, 9, then a strobe in the WON-entry cycle.
        cyc("win_new", 1'b0, 1'b1, 9, 1'b0, 0);
        cyc("win_g3", 1'b0, 1'b0, 2, 1'b1, 3);
        cyc("win_gap", 1'b0, 1'b0, 2, 1'b0, 0);
        cyc("win_g12", 1'b0, 1'b0, 2, 1'b1, 12);
        cyc("win_g9", 1'b0, 1'b0, 2, 1'b1, 9);
        cyc("win_ignored", 1'b0, 1'b0, 2, 1'b1, 1);

        // Loss path: target 0, guesses 1..8 back to back, then a 9th strobe.
        cyc("loss_new", 1'b0, 1'b1, 0, 1'b0, 0);
        for (int i = 1; i <= 8; i++) cyc("loss_g", 1'b0, 1'b0, 5, 1'b1, i);
        cyc("loss_g9", 1'b0, 1'b0, 5, 1'b1, 9);
        cyc("loss_hold", 1'b0, 1'b0, 5, 1'b0, 0);

        // Match on the final allowed attempt: target 6, seven misses, then 6.
        cyc("last_new", 1'b0, 1'b1, 6, 1'b0, 0);
        for (int i = 0; i < 7; i++) cyc("last_miss", 1'b0, 1'b0, 1, 1'b1, (i < 3) ? i : i + 8);
        cyc("last_hit", 1'b0, 1'b0, 1, 1'b1, 6);

        // Back-to-back: target 7, guesses 2 then 15.
        cyc("b2b_new", 1'b0, 1'b1, 7, 1'b0, 0);
        cyc("b2b_g2", 1'b0, 1'b0, 3, 1'b1, 2);
        cyc("b2b_g15", 1'b0, 1'b0, 3, 1'b1, 15);

        // NewGame and a guess together: the guess is dropped.
        cyc("both_new", 1'b0, 1'b1, 4, 1'b1, 4);
        cyc("both_g1", 1'b0, 1'b0, 3, 1'b1, 1);
        // Reset mid-game overrides a simultaneous NewGame and guess.
        cyc("mid_rst", 1'b1, 1'b1, 11, 1'b1, 3);
        cyc("post_rst", 1'b0, 1'b0, 11, 1'b1, 3);

        // Randomized play against the reference model.
        for (int n = 0; n < 600; n++) begin
            cyc("rand",
                ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 14) == 0),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_guess_checker
